// File: rtl/chan_scan_seq.sv
// Channel scan sequencer: walks the set bits of a latched 8-bit mask in ascending
// order and offers each 3-bit code over valid/ready, with optional dwell and looping.
module chan_scan_seq #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               loop,
    input  logic [7:0]         en_mask,
    input  logic [DWELL_W-1:0] dwell,
    output logic [2:0]         sel,
    output logic               sel_valid,
    input  logic               sel_ready,
    output logic               busy,
    output logic               done,
    output logic [7:0]         pass_cnt
);

    typedef enum logic [1:0] {IDLE, PRESENT, DWELL} state_t;

    state_t             state;
    logic [7:0]         mask_q;
    logic [DWELL_W-1:0] dwell_q;
    logic [DWELL_W-1:0] cnt;
    logic               loop_q;
    logic               stop_pend;

    // Returns {found, index} of the lowest set bit of m at or above position from.
    function automatic logic [3:0] find_from(input logic [7:0] m, input logic [3:0] from);
        logic [3:0] r;
        r = '0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i] && (4'(i) >= from)) r = {1'b1, 3'(i)};
        end
        return r;
    endfunction

    logic [3:0] above;
    logic [3:0] first;
    logic [3:0] start_first;
    logic       accept;
    logic       stop_now;
    logic       pass_end;
    logic [2:0] next_code;

    assign above       = find_from(mask_q, {1'b0, sel} + 4'd1);
    assign first       = find_from(mask_q, 4'd0);
    assign start_first = find_from(en_mask, 4'd0);
    assign accept      = sel_valid && sel_ready;
    assign stop_now    = stop || stop_pend;
    assign pass_end    = !above[3];
    assign next_code   = pass_end ? first[2:0] : above[2:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            mask_q    <= '0;
            dwell_q   <= '0;
            loop_q    <= 1'b0;
            cnt       <= '0;
            stop_pend <= 1'b0;
            sel       <= '0;
            sel_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass_cnt  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && (en_mask != 8'd0)) begin
                        mask_q    <= en_mask;
                        dwell_q   <= dwell;
                        loop_q    <= loop;
                        pass_cnt  <= '0;
                        sel       <= start_first[2:0];
                        sel_valid <= 1'b1;
                        busy      <= 1'b1;
                        stop_pend <= 1'b0;
                        state     <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (stop) stop_pend <= 1'b1;
                    if (accept) begin
                        if (pass_end) pass_cnt <= pass_cnt + 8'd1;
                        if (stop_now || (pass_end && !loop_q)) begin
                            state     <= IDLE;
                            sel_valid <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            stop_pend <= 1'b0;
                        end else begin
                            // sel may move early: it is not observed while sel_valid is low
                            sel <= next_code;
                            if (dwell_q != '0) begin
                                sel_valid <= 1'b0;
                                cnt       <= dwell_q;
                                state     <= DWELL;
                            end
                        end
                    end
                end
                DWELL: begin
                    if (stop_now) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        stop_pend <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                        if (cnt == {{(DWELL_W-1){1'b0}}, 1'b1}) begin
                            sel_valid <= 1'b1;
                            state     <= PRESENT;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_chan_scan_seq.sv
// Scoreboard bench for chan_scan_seq: expected codes are queued when a scan is
// requested and checked, with gap, hold, pass count and done, on each acceptance.
module tb_chan_scan_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       stop;
    logic       loop;
    logic [7:0] en_mask;
    logic [7:0] dwell;
    logic [2:0] sel;
    logic       sel_valid;
    logic       sel_ready;
    logic       busy;
    logic       done;
    logic [7:0] pass_cnt;

    chan_scan_seq #(.DWELL_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .loop(loop),
        .en_mask(en_mask), .dwell(dwell), .sel(sel), .sel_valid(sel_valid),
        .sel_ready(sel_ready), .busy(busy), .done(done), .pass_cnt(pass_cnt)
    );

    always #5 clk = ~clk;

    int         errors = 0;
    int         checks = 0;
    logic [2:0] exp_q[$];
    logic [7:0] cur_mask = '0;
    logic       cur_loop = 1'b0;
    logic       stop_req = 1'b0;
    int         exp_gap = 0;
    logic [7:0] exp_pass = '0;
    int         done_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] highest(input logic [7:0] m);
        logic [2:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) if (m[i]) r = 3'(i);
        return r;
    endfunction

    // Monitor: sampled on the falling edge, away from the active edge.
    logic       prev_pend = 1'b0;
    logic [2:0] prev_sel = '0;
    logic       prev_done = 1'b0;
    logic       have_prev = 1'b0;
    logic       chk_pass = 1'b0;
    logic       exp_done = 1'b0;
    int         gap = 0;

    always @(negedge clk) begin
        if (rst) begin
            prev_pend = 1'b0;
            prev_done = 1'b0;
            have_prev = 1'b0;
            chk_pass  = 1'b0;
            exp_done  = 1'b0;
            gap       = 0;
        end else begin
            if (done) done_cnt++;
            if (prev_done) check("done_width", done, 0);
            prev_done = done;
            if (exp_done) begin
                check("done_pulse", done, 1);
                check("busy_end", busy, 0);
                exp_done = 1'b0;
            end
            if (chk_pass) begin
                check("pass_cnt", pass_cnt, exp_pass);
                chk_pass = 1'b0;
            end
            if (prev_pend) begin
                check("hold_valid", sel_valid, 1);
                check("hold_sel", sel, prev_sel);
            end
            if (!busy) have_prev = 1'b0;
            if (busy && !sel_valid) gap++;
            if (sel_valid && sel_ready) begin
                check("q_nonempty", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) check("sel", sel, exp_q.pop_front());
                if (have_prev) check("gap", gap, exp_gap);
                have_prev = 1'b1;
                gap = 0;
                if (sel == highest(cur_mask)) begin
                    exp_pass++;
                    chk_pass = 1'b1;
                    if (!cur_loop) exp_done = 1'b1;
                end
                if (stop_req) exp_done = 1'b1;
            end
            prev_pend = sel_valid && !sel_ready;
            prev_sel  = sel;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_scan(input logic [7:0] m, input logic [7:0] d, input logic lp);
        en_mask  = m;
        dwell    = d;
        loop     = lp;
        cur_mask = m;
        cur_loop = lp;
        exp_gap  = d;
        exp_pass = '0;
        stop_req = 1'b0;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    task automatic wait_q_empty(input int limit, input logic rnd);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < limit) begin
            if (rnd) sel_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        check("timeout_q", exp_q.size(), 0);
        sel_ready = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while (busy && n < limit) begin
            tick();
            n++;
        end
        check("timeout_idle", busy, 0);
        tick();
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_sel"}, sel, 0);
        check({tag, "_valid"}, sel_valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_pass"}, pass_cnt, 0);
    endtask

    initial begin
        int d0;
        int n;
        rst = 1'b1; start = 1'b0; stop = 1'b0; loop = 1'b0;
        en_mask = '0; dwell = '0; sel_ready = 1'b0;
        #1;
        check_zero("reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        tick();
        check_zero("idle");

        // Empty mask start is ignored
        d0 = done_cnt;
        start_scan(8'h00, 8'd0, 1'b0);
        repeat (3) tick();
        check("mask0_busy", busy, 0);
        check("mask0_done", done_cnt, d0);

        // Single pass, back-to-back
        d0 = done_cnt;
        exp_q.push_back(3'd0); exp_q.push_back(3'd2);
        exp_q.push_back(3'd5); exp_q.push_back(3'd7);
        sel_ready = 1'b1;
        start_scan(8'hA5, 8'd0, 1'b0);
        check("a5_first_valid", sel_valid, 1);
        sel_ready = 1'b1;
        wait_q_empty(20, 1'b0);
        wait_idle(10);
        check("a5_done_cnt", done_cnt, d0 + 1);
        check("a5_pass", pass_cnt, 1);

        // Looping with dwell 3 and random ready, then stop while 4 is held
        for (int k = 0; k < 7; k++) exp_q.push_back(k[0] ? 3'd4 : 3'd1);
        start_scan(8'h12, 8'd3, 1'b1);
        wait_q_empty(300, 1'b1);
        n = 0;
        while (!sel_valid && n < 20) begin
            tick();
            n++;
        end
        check("stop_present_sel", sel, 4);
        d0 = done_cnt;
        stop = 1'b1; stop_req = 1'b1;
        tick();
        stop = 1'b0;
        repeat (4) tick();
        check("stop_hold_busy", busy, 1);
        exp_q.push_back(3'd4);
        sel_ready = 1'b1;
        wait_idle(10);
        sel_ready = 1'b0;
        check("stop_present_done", done_cnt, d0 + 1);
        check("loop12_pass", pass_cnt, 4);

        // Stop during dwell
        exp_q.push_back(3'd1);
        sel_ready = 1'b1;
        start_scan(8'h12, 8'd5, 1'b1);
        wait_q_empty(10, 1'b0);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("stop_dwell_busy", busy, 0);
        check("stop_dwell_done", done, 1);
        check("stop_dwell_valid", sel_valid, 0);
        tick();

        // Single channel, looping: 300 acceptances wrap pass_cnt to 44
        for (int k = 0; k < 300; k++) exp_q.push_back(3'd7);
        sel_ready = 1'b1;
        start_scan(8'h80, 8'd0, 1'b1);
        sel_ready = 1'b1;
        wait_q_empty(400, 1'b0);
        check("wrap_pass", pass_cnt, 44);
        stop = 1'b1; stop_req = 1'b1;
        tick();
        stop = 1'b0;
        exp_q.push_back(3'd7);
        sel_ready = 1'b1;
        wait_idle(10);
        sel_ready = 1'b0;

        // Reset mid-DWELL
        d0 = done_cnt;
        exp_q.push_back(3'd1);
        sel_ready = 1'b1;
        start_scan(8'h12, 8'd5, 1'b1);
        wait_q_empty(10, 1'b0);
        tick();
        #2 rst = 1'b1;
        #1;
        check_zero("rst_dwell");
        #3 rst = 1'b0;
        tick();
        check("rst_dwell_nodone", done_cnt, d0);

        // Reset mid-PRESENT
        start_scan(8'h06, 8'd0, 1'b1);
        tick();
        check("pre_rst_valid", sel_valid, 1);
        #2 rst = 1'b1;
        #1;
        check_zero("rst_present");
        #3 rst = 1'b0;
        tick();
        check("rst_present_nodone", done_cnt, d0);

        // Normal scan after reset, dwell 1
        d0 = done_cnt;
        for (int k = 0; k < 4; k++) exp_q.push_back(3'(k));
        sel_ready = 1'b1;
        start_scan(8'h0F, 8'd1, 1'b0);
        sel_ready = 1'b1;
        wait_q_empty(30, 1'b0);
        wait_idle(10);
        check("post_rst_done", done_cnt, d0 + 1);
        check("post_rst_pass", pass_cnt, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
